// File: rtl/sirene_pkg.sv
// Shared types and helpers for the siren control stage.
// Holds the FSM state encoding and the ticks_left width calculation.
package sirene_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2
    } estado_t;

    // Bits needed to hold the largest tick count loaded into ticks_left
    function automatic int largura_ticks(input int duracao, input int resfriamento);
        int maior;
        maior = (duracao > resfriamento) ? duracao : resfriamento;
        return (maior < 1) ? 1 : $clog2(maior + 1);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for an asynchronous input, with optional rising-edge output.
// Latency: level valid 2 cycles after input; edge is a one-cycle pulse; no backpressure.
module sincronizador #(
    parameter bit DETECTA_BORDA = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel,
    output logic borda
);

    logic s1;
    logic s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
        end
    end

    assign nivel = s2;

    generate
        if (DETECTA_BORDA) begin : g_borda
            logic s3;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s3 <= 1'b0;
                end else begin
                    s3 <= s2;
                end
            end

            assign borda = s2 & ~s3;
        end else begin : g_sem_borda
            assign borda = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/controle_sirene.sv
// Siren control: 2 Hz prescaler plus IDLE/RUN/COOLDOWN FSM driving gerador_sirene.
// Latency: trigger/cancel act 2 cycles after sampling; no backpressure, strobe free-runs.
module controle_sirene
    import sirene_pkg::*;
#(
    parameter int HALF_SEC_CYCLES = 50_000_000,
    parameter int DURATION_TICKS  = 20,
    parameter int COOLDOWN_TICKS  = 4,
    parameter int TICKS_W         = largura_ticks(DURATION_TICKS, COOLDOWN_TICKS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               trigger,
    input  logic               cancel,
    output logic               eneble_siren,
    output logic               two_hz_enable,
    output logic               busy,
    output logic [TICKS_W-1:0] ticks_left
);

    localparam int                  PRESC_W   = $clog2(HALF_SEC_CYCLES);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(HALF_SEC_CYCLES - 1);
    localparam logic [PRESC_W-1:0]  PRESC_UM  = PRESC_W'(1);
    localparam logic [TICKS_W-1:0]  T_RUN     = TICKS_W'(DURATION_TICKS);
    localparam logic [TICKS_W-1:0]  T_COOL    = TICKS_W'(COOLDOWN_TICKS);
    localparam logic [TICKS_W-1:0]  T_UM      = TICKS_W'(1);
    localparam logic [TICKS_W-1:0]  T_ZERO    = '0;
    // With no cooldown configured, leaving RUN lands straight back in IDLE
    localparam estado_t             POS_RUN   = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;

    estado_t              estado;
    estado_t              estado_prox;
    logic [TICKS_W-1:0]   ticks_prox;
    logic [PRESC_W-1:0]   presc;
    logic                 trig_edge;
    logic                 cancel_sync;
    logic                 inicia;
    logic                 trig_nivel_unused;
    logic                 cancel_borda_unused;

    sincronizador #(.DETECTA_BORDA(1'b1)) u_sinc_trigger (
        .clock   (clock),
        .reset   (reset),
        .entrada (trigger),
        .nivel   (trig_nivel_unused),
        .borda   (trig_edge)
    );

    sincronizador #(.DETECTA_BORDA(1'b0)) u_sinc_cancel (
        .clock   (clock),
        .reset   (reset),
        .entrada (cancel),
        .nivel   (cancel_sync),
        .borda   (cancel_borda_unused)
    );

    assign inicia = (estado == IDLE) && trig_edge;

    // Restarting the prescaler on a fresh run makes every run exactly DURATION strobes long
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc         <= '0;
            two_hz_enable <= 1'b0;
        end else if (inicia) begin
            presc         <= '0;
            two_hz_enable <= 1'b0;
        end else if (presc == PRESC_MAX) begin
            presc         <= '0;
            two_hz_enable <= 1'b1;
        end else begin
            presc         <= presc + PRESC_UM;
            two_hz_enable <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= IDLE;
            ticks_left <= '0;
        end else begin
            estado     <= estado_prox;
            ticks_left <= ticks_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        ticks_prox  = ticks_left;
        case (estado)
            IDLE: begin
                if (trig_edge) begin
                    estado_prox = RUN;
                    ticks_prox  = T_RUN;
                end
            end
            RUN: begin
                if (cancel_sync) begin
                    estado_prox = POS_RUN;
                    ticks_prox  = T_COOL;
                end else if (trig_edge) begin
                    ticks_prox  = T_RUN;
                end else if (two_hz_enable) begin
                    if (ticks_left > T_UM) begin
                        ticks_prox  = ticks_left - T_UM;
                    end else begin
                        estado_prox = POS_RUN;
                        ticks_prox  = T_COOL;
                    end
                end
            end
            COOLDOWN: begin
                if (two_hz_enable) begin
                    if (ticks_left > T_UM) begin
                        ticks_prox  = ticks_left - T_UM;
                    end else begin
                        estado_prox = IDLE;
                        ticks_prox  = T_ZERO;
                    end
                end
            end
            default: begin
                estado_prox = IDLE;
                ticks_prox  = T_ZERO;
            end
        endcase
    end

    assign eneble_siren = (estado == RUN);
    assign busy         = (estado == RUN) || (estado == COOLDOWN);

endmodule

// File: tb/tb_controle_sirene.sv
// Directed bench for controle_sirene with HALF_SEC_CYCLES=4, DURATION_TICKS=3.
// Main instance uses COOLDOWN_TICKS=2; a second instance uses COOLDOWN_TICKS=0.
module tb_controle_sirene;

    logic       clock;
    logic       reset;
    logic       trigger;
    logic       cancel;
    logic       eneble_siren;
    logic       two_hz_enable;
    logic       busy;
    logic [1:0] ticks_left;

    logic       trigger2;
    logic       cancel2;
    logic       eneble2;
    logic       strobe2;
    logic       busy2;
    logic [1:0] ticks2;

    int n_tests;
    int n_fail;

    controle_sirene #(
        .HALF_SEC_CYCLES (4),
        .DURATION_TICKS  (3),
        .COOLDOWN_TICKS  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .trigger       (trigger),
        .cancel        (cancel),
        .eneble_siren  (eneble_siren),
        .two_hz_enable (two_hz_enable),
        .busy          (busy),
        .ticks_left    (ticks_left)
    );

    controle_sirene #(
        .HALF_SEC_CYCLES (4),
        .DURATION_TICKS  (3),
        .COOLDOWN_TICKS  (0)
    ) dut_sc (
        .clock         (clock),
        .reset         (reset),
        .trigger       (trigger2),
        .cancel        (cancel2),
        .eneble_siren  (eneble2),
        .two_hz_enable (strobe2),
        .busy          (busy2),
        .ticks_left    (ticks2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_ticks;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        trigger  = 1'b0;
        cancel   = 1'b0;
        trigger2 = 1'b0;
        cancel2  = 1'b0;
        #12;

        // Reset values
        check("rst_en",     eneble_siren,  0);
        check("rst_strobe", two_hz_enable, 0);
        check("rst_busy",   busy,          0);
        check("rst_ticks",  ticks_left,    0);
        check("rst_en2",    eneble2,       0);
        check("rst_ticks2", ticks2,        0);
        step();
        reset = 1'b1;
        repeat (3) step();

        // Basic run: trigger sampled at edge 0
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            step();
            exp_ticks = (e < 2)  ? 0 :
                        (e <= 6)  ? 3 :
                        (e <= 10) ? 2 :
                        (e <= 14) ? 1 :
                        (e <= 18) ? 2 :
                        (e <= 22) ? 1 : 0;
            check($sformatf("run_en@%0d", e),    eneble_siren, (e >= 2 && e <= 14));
            check($sformatf("run_busy@%0d", e),  busy,         (e >= 2 && e <= 22));
            check($sformatf("run_ticks@%0d", e), ticks_left,   exp_ticks);
            if (e >= 2)
                check($sformatf("run_strobe@%0d", e), two_hz_enable,
                      (e == 6 || e == 10 || e == 14 || e == 18 || e == 22));
        end

        // Retrigger landing on the same edge as a strobe: reload, no decrement
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 10) begin
                check("rt_ticks@10",  ticks_left,    2);
                check("rt_strobe@10", two_hz_enable, 1);
            end
            if (e == 11) check("rt_reload@11", ticks_left, 3);
            if (e == 14) check("rt_ticks@14",  ticks_left, 3);
            if (e == 15) check("rt_ticks@15",  ticks_left, 2);
            if (e == 22) begin
                check("rt_en@22",    eneble_siren, 1);
                check("rt_ticks@22", ticks_left,   1);
            end
            if (e == 23) begin
                check("rt_en@23",    eneble_siren, 0);
                check("rt_busy@23",  busy,         1);
                check("rt_ticks@23", ticks_left,   2);
            end
            if (e == 27) check("rt_ticks@27", ticks_left, 1);
            if (e == 31) begin
                check("rt_busy@31",  busy,       0);
                check("rt_ticks@31", ticks_left, 0);
            end
            if (e == 8) trigger = 1'b1;
            if (e == 9) trigger = 1'b0;
        end

        // Cancel mid-run, then a trigger during COOLDOWN is ignored
        repeat (3) step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 6) begin
                check("cn_en@6",   eneble_siren, 1);
                check("cn_busy@6", busy,         1);
            end
            if (e == 7) begin
                check("cn_en@7",    eneble_siren, 0);
                check("cn_busy@7",  busy,         1);
                check("cn_ticks@7", ticks_left,   2);
            end
            if (e == 11) check("cn_ticks@11", ticks_left, 1);
            if (e == 13) begin
                check("cn_en@13",    eneble_siren, 0);
                check("cn_busy@13",  busy,         1);
                check("cn_ticks@13", ticks_left,   1);
            end
            if (e == 15) begin
                check("cn_busy@15",  busy,       0);
                check("cn_ticks@15", ticks_left, 0);
            end
            if (e == 18) begin
                check("cn_busy@18", busy,         0);
                check("cn_en@18",   eneble_siren, 0);
            end
            if (e == 4)  cancel  = 1'b1;
            if (e == 8)  trigger = 1'b1;
            if (e == 9)  trigger = 1'b0;
            if (e == 12) cancel  = 1'b0;
        end

        // Zero cooldown: last strobe returns to IDLE, new trigger accepted at once
        trigger2 = 1'b1;
        step();
        trigger2 = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (e == 14) begin
                check("nc_en@14",    eneble2, 1);
                check("nc_ticks@14", ticks2,  1);
            end
            if (e == 15) begin
                check("nc_en@15",    eneble2, 0);
                check("nc_busy@15",  busy2,   0);
                check("nc_ticks@15", ticks2,  0);
            end
            if (e == 17) begin
                check("nc_en@17",    eneble2, 1);
                check("nc_busy@17",  busy2,   1);
                check("nc_ticks@17", ticks2,  3);
            end
            if (e == 14) trigger2 = 1'b1;
            if (e == 15) trigger2 = 1'b0;
        end

        // Asynchronous reset in the middle of a run, while the strobe is high
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (10) step();
        check("ar_strobe_pre", two_hz_enable, 1);
        check("ar_en_pre",     eneble_siren,  1);
        check("ar_ticks_pre",  ticks_left,    2);
        reset = 1'b0;
        #1;
        check("ar_en",     eneble_siren,  0);
        check("ar_strobe", two_hz_enable, 0);
        check("ar_busy",   busy,          0);
        check("ar_ticks",  ticks_left,    0);
        check("ar_en2",    eneble2,       0);
        repeat (2) step();
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ar_rel_strobe@%0d", k), two_hz_enable, (k == 4));
            check($sformatf("ar_rel_busy@%0d", k),   busy,          0);
        end

        // Trigger held high: one run only, no reload from the level
        trigger = 1'b1;
        step();
        for (int e = 1; e <= 49; e++) begin
            step();
            if (e == 2) begin
                check("hd_en@2",    eneble_siren, 1);
                check("hd_ticks@2", ticks_left,   3);
            end
            if (e == 11) check("hd_ticks@11", ticks_left, 1);
            if (e == 15) begin
                check("hd_en@15",   eneble_siren, 0);
                check("hd_busy@15", busy,         1);
            end
            if (e == 30) check("hd_busy@30", busy, 0);
            if (e == 49) begin
                check("hd_busy@49", busy,         0);
                check("hd_en@49",   eneble_siren, 0);
            end
        end
        trigger = 1'b0;
        repeat (5) step();
        check("hd_release_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
